rv32m_muldiv_seq: RTL and testbench



---
 rtl/rv32m_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/rv32m_muldiv_seq.sv | 120 ++++++++++++
 tb/tb_rv32m_muldiv_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// Shared encodings and constants for the sequential RV32M multiply/divide unit.
package rv32m_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic          ge;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    shifted = {hi, lo[XLEN-1]};
    ge      = shifted >= {1'b0, opb};
    hi_next = '0;
    lo_next = '0;
    if (is_div) begin
      // The remainder stays below the divisor, so the difference always fits in XLEN bits.
      hi_next = ge ? (shifted[XLEN-1:0] - opb) : shifted[XLEN-1:0];
      lo_next = {lo[XLEN-2:0], ge};
    end else begin
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/rv32m_muldiv_seq.sv
// Iterative RV32M multiply/divide: magnitudes through 32 single-bit steps, sign fixup at the end.
module rv32m_muldiv_seq
  import rv32m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       op_reg;
  logic             neg_reg;
  logic [XLEN-1:0]  opb_reg, hi_reg, lo_reg, result_reg;
  logic [XLEN-1:0]  hi_step, lo_step;

  logic             a_sgn, b_sgn, a_neg, b_neg, div0, ovf, special, accept, last_iter;
  logic [XLEN-1:0]  a_mag, b_mag, special_val, fix_val;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin
    a_sgn = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    b_sgn = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  end

  assign a_neg     = a_sgn & rs1_val[XLEN-1];
  assign b_neg     = b_sgn & rs2_val[XLEN-1];
  assign a_mag     = a_neg ? -rs1_val : rs1_val;
  assign b_mag     = b_neg ? -rs2_val : rs2_val;
  assign div0      = op[2] && (rs2_val == '0);
  assign ovf       = op[2] && b_sgn && (rs1_val == INT_MIN) && (rs2_val == '1);
  assign special   = div0 | ovf;
  assign busy      = (state_reg == ST_CALC) || (state_reg == ST_FIX);
  assign done      = (state_reg == ST_DONE);
  assign accept    = start & ~kill & ~busy;
  assign last_iter = (cnt_reg == CNT_W'(XLEN-1));
  assign result    = result_reg;

  // op[1] separates remainder from quotient among the divide encodings.
  always_comb begin
    if (div0) special_val = op[1] ? rs1_val : DIV0_QUOT;
    else      special_val = op[1] ? '0 : INT_MIN;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_reg[2]),
    .hi      (hi_reg),
    .lo      (lo_reg),
    .opb     (opb_reg),
    .hi_next (hi_step),
    .lo_next (lo_step)
  );

  always_comb begin
    prod     = {hi_reg, lo_reg};
    prod_fix = neg_reg ? -prod : prod;
    case (op_reg)
      MD_MUL:                       fix_val = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_val = neg_reg ? -lo_reg : lo_reg;
      default:                      fix_val = neg_reg ? -hi_reg : hi_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: state_next = accept ? (special ? ST_DONE : ST_CALC) : ST_IDLE;
      ST_CALC: begin
        if (kill)           state_next = ST_IDLE;
        else if (last_iter) state_next = ST_FIX;
      end
      ST_FIX:  state_next = kill ? ST_IDLE : ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      op_reg     <= '0;
      neg_reg    <= 1'b0;
      opb_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      result_reg <= '0;
    end else if (accept) begin
      cnt_reg <= '0;
      op_reg  <= op;
      // Remainder takes the dividend's sign; everything else the XOR of operand signs.
      neg_reg <= (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
      opb_reg <= b_mag;
      hi_reg  <= '0;
      lo_reg  <= a_mag;
      if (special) result_reg <= special_val;
    end else if (state_reg == ST_CALC && !kill) begin
      hi_reg  <= hi_step;
      lo_reg  <= lo_step;
      cnt_reg <= cnt_reg + CNT_W'(1);
    end else if (state_reg == ST_FIX && !kill) begin
      result_reg <= fix_val;
    end
  end

endmodule

// File: tb/tb_rv32m_muldiv_seq.sv
// Self-checking bench: directed vector table, kill/reset/back-to-back sequences, random ops vs arithmetic model.
module tb_rv32m_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_exp = '0;

  rv32m_muldiv_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .kill    (kill),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Arithmetic reference: wide signed/unsigned math, truncating division as in RISC-V.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] u;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
      3'd3: begin u = {32'd0, a} * {32'd0, b}; r = u[63:32]; end
      3'd4: begin if (b == 0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: begin
        case ($urandom_range(0, 5))
          0: return 32'h0000_0000;
          1: return 32'h0000_0001;
          2: return 32'hFFFF_FFFF;
          3: return 32'h8000_0000;
          4: return 32'h7FFF_FFFF;
          default: return 32'h0000_0002;
        endcase
      end
      1: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called #1 after the start edge (cycle 1); returns the cycle index in which done is seen.
  task automatic wait_done(input int poke, output int lat, output logic busy_bad);
    int cyc;
    cyc = 1;
    busy_bad = 1'b0;
    while (!done && cyc < 60) begin
      if (cyc == poke) begin
        start = 1'b1; op = 3'd4; rs1_val = 32'd99; rs2_val = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    lat = cyc;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input int poke, input string name);
    int   lat;
    logic busy_bad;
    op = f; rs1_val = a; rs2_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(poke, lat, busy_bad);
    $display("[TB] %s op=%0d a=%h b=%h result=%h exp=%h lat=%0d", name, f, a, b, result, exp_res, lat);
    check_val({name, " result"}, result, exp_res);
    check_int({name, " latency"}, lat, exp_lat);
    check_val({name, " busy_during_op"}, {31'd0, busy_bad}, 32'd0);
    check_val({name, " busy_in_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check_val({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
    last_exp = exp_res;
  endtask

  initial begin
    int          lat;
    logic        busy_bad;
    logic        saw_done;
    logic [31:0] prior;
    logic [2:0]  f;
    logic [31:0] a, b;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[11] = '{3'd7, 32'd9,          32'd0,         32'd9,         1};
    vecs[12] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[13] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; rs1_val = '0; rs2_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset busy", {31'd0, busy}, 32'd0);
    check_val("reset done", {31'd0, done}, 32'd0);
    check_val("reset result", result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].lat, 0, $sformatf("vec%0d", i));

    // start pulsed while busy must be ignored
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 5, "start_while_busy");

    // kill at cycle 10 of a DIV
    prior = last_exp;
    op = 3'd4; rs1_val = 32'd100; rs2_val = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    if (done) saw_done = 1'b1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    $display("[TB] kill busy=%b done=%b result=%h", busy, done, result);
    check_val("kill busy_after", {31'd0, busy}, 32'd0);
    check_val("kill no_done", {31'd0, done | saw_done}, 32'd0);
    check_val("kill result_held", result, prior);
    do_op(3'd0, 32'd3, 32'd4, 32'd12, 34, 0, "after_kill");

    // asynchronous reset between edges mid-CALC
    op = 3'd0; rs1_val = 32'd5; rs2_val = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    $display("[TB] async_reset busy=%b done=%b result=%h", busy, done, result);
    check_val("async_rst busy", {31'd0, busy}, 32'd0);
    check_val("async_rst done", {31'd0, done}, 32'd0);
    check_val("async_rst result", result, 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("post_rst idle", {31'd0, busy | done}, 32'd0);

    // back-to-back: second start issued in the DONE cycle of the first
    op = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, lat, busy_bad);
    $display("[TB] b2b_first result=%h lat=%0d", result, lat);
    check_val("b2b first result", result, 32'd100);
    check_int("b2b first latency", lat, 34);
    op = 3'd0; rs1_val = 32'h0001_2345; rs2_val = 32'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("b2b accepted busy", {31'd0, busy}, 32'd1);
    wait_done(0, lat, busy_bad);
    $display("[TB] b2b_second result=%h lat=%0d", result, lat);
    check_val("b2b second result", result, 32'h0012_3450);
    check_int("b2b second latency", lat, 34);
    @(posedge clk); #1;

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      do_op(f, a, b, ref_res(f, a, b), ref_lat(f, a, b), 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
